// File: rtl/data_requester.sv
// Outstanding-read tracker toward the DataInterface read port; in-order delivery.
// Optional: DATA_REQUESTER_ADDR_CHECK_EN flags returns whose address differs from the slot.
package DataInterface_pkg;

    localparam int ADDR_W = 8;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef union packed {
        logic [127:0]     raw;
        logic [3:0][31:0] u32;
    } data_register_union_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] request_id;
        logic [3:0] receive_id;
        addr_t      read_address;
    } read_request_t;

    typedef struct packed {
        logic                 valid;
        logic [3:0]           request_id;
        logic [3:0]           receive_id;
        addr_t                read_address;
        data_register_union_t data;
    } read_return_t;

endpackage

module data_requester
    import DataInterface_pkg::*;
#(
    parameter int unsigned REQUESTER_ID = 7,
    parameter int unsigned DEPTH        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 halt,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  addr_t                cmd_address,
    output read_request_t        read_req,
    input  read_return_t         read_back,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output addr_t                rsp_address,
    output data_register_union_t rsp_data,
    output logic                 err
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [3:0] RID = 4'(REQUESTER_ID);

    typedef enum logic [1:0] {
        FREE,
        PENDING,
        FILLED
    } slot_e;

    slot_e                st        [DEPTH];
    addr_t                slot_addr [DEPTH];
    data_register_union_t slot_data [DEPTH];

    logic [IW-1:0] head;
    logic [IW-1:0] tail;
    logic [IW-1:0] rid;
    logic          accept;
    logic          deliver;
    logic          ret_hit;
    logic          in_range;
    logic          ret_ok;
    logic          addr_bad;

    assign cmd_ready   = (st[tail] == FREE) && !halt;
    assign accept      = cmd_valid && cmd_ready;
    assign rsp_valid   = (st[head] == FILLED);
    assign deliver     = rsp_valid && rsp_ready;
    assign rsp_address = slot_addr[head];
    assign rsp_data    = slot_data[head];

    assign rid      = read_back.receive_id[IW-1:0];
    assign ret_hit  = read_back.valid && (read_back.request_id == RID);
    assign in_range = 32'(read_back.receive_id) < DEPTH;
    assign ret_ok   = ret_hit && in_range && (st[rid] == PENDING);

`ifdef DATA_REQUESTER_ADDR_CHECK_EN
    assign addr_bad = ret_ok && (read_back.read_address != slot_addr[rid]);
`else
    logic unused_ret_addr;
    assign unused_ret_addr = ^read_back.read_address;
    assign addr_bad = 1'b0;
`endif

    // Accept, capture and delivery always touch distinct slots
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                st[i] <= FREE;
            end
            head     <= '0;
            tail     <= '0;
            read_req <= '0;
            err      <= 1'b0;
        end else begin
            if (accept) begin
                st[tail] <= PENDING;
                tail     <= tail + 1'b1;
                read_req <= '{
                    valid:        1'b1,
                    request_id:   RID,
                    receive_id:   4'(tail),
                    read_address: cmd_address
                };
            end else begin
                read_req <= '0;
            end
            if (ret_ok) begin
                st[rid] <= FILLED;
            end
            if (deliver) begin
                st[head] <= FREE;
                head     <= head + 1'b1;
            end
            if ((ret_hit && !ret_ok) || addr_bad) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            slot_addr[tail] <= cmd_address;
        end
        if (ret_ok) begin
            slot_data[rid] <= read_back.data;
        end
    end

endmodule

// File: tb/tb_data_requester.sv
// Scoreboard bench for data_requester: request and response queues checked by a monitor.
module tb_data_requester;
    import DataInterface_pkg::*;

    typedef struct packed {
        addr_t                a;
        data_register_union_t d;
    } rsp_t;

    logic                 clk = 0;
    logic                 rst = 0;
    logic                 halt = 0;
    logic                 cmd_valid = 0;
    logic                 cmd_ready;
    addr_t                cmd_address = '0;
    read_request_t        read_req;
    read_return_t         read_back = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1;
    addr_t                rsp_address;
    data_register_union_t rsp_data;
    logic                 err;

    int checks   = 0;
    int failures = 0;

    read_request_t exp_req[$];
    rsp_t          exp_rsp[$];

    data_requester #(.REQUESTER_ID(7), .DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .halt(halt),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_address(cmd_address),
        .read_req(read_req),
        .read_back(read_back),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_address(rsp_address),
        .rsp_data(rsp_data),
        .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic data_register_union_t mk(input addr_t a);
        data_register_union_t d;
        d.u32[0] = 32'h1111_0000 + 32'(a);
        d.u32[1] = 32'h2222_0000 + 32'(a);
        d.u32[2] = 32'h3333_0000 + 32'(a);
        d.u32[3] = 32'(a);
        return d;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Monitor: pops expected items whenever the DUT presents them
    always @(negedge clk) begin
        read_request_t er;
        rsp_t          ep;
        if (rst && read_req.valid) begin
            checks++;
            if (exp_req.size() == 0) begin
                failures++;
                $display("FAIL req_unexpected got=%h", read_req);
            end else begin
                er = exp_req.pop_front();
                if (read_req !== er) begin
                    failures++;
                    $display("FAIL req got=%h exp=%h", read_req, er);
                end
            end
        end
        if (rst && rsp_valid && rsp_ready) begin
            checks++;
            if (exp_rsp.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected addr=%h", rsp_address);
            end else begin
                ep = exp_rsp.pop_front();
                if (rsp_address !== ep.a || rsp_data !== ep.d) begin
                    failures++;
                    $display("FAIL rsp got=%h/%h exp=%h/%h",
                             rsp_address, rsp_data, ep.a, ep.d);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input addr_t a, input logic [3:0] rcv);
        int n = 0;
        cmd_valid   = 1;
        cmd_address = a;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!cmd_ready) begin
            failures++;
            $display("FAIL cmd_accept_timeout got=0 exp=1");
        end else begin
            exp_req.push_back('{valid: 1'b1, request_id: 4'd7,
                                receive_id: rcv, read_address: a});
        end
        tick();
        cmd_valid = 0;
    endtask

    task automatic ret(input logic [3:0] id, input logic [3:0] rcv,
                       input addr_t a, input data_register_union_t d);
        read_back = '{valid: 1'b1, request_id: id, receive_id: rcv,
                      read_address: a, data: d};
        tick();
        read_back = '0;
    endtask

    task automatic do_reset;
        rst = 0;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'(!halt));
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_req_valid", 32'(read_req.valid), 0);
        chk("rst_err", 32'(err), 0);
        exp_req.delete();
        exp_rsp.delete();
        tick();
        rst = 1;
        tick();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_rsp.size() != 0 || exp_req.size() != 0) && n < 30) begin
            tick();
            n++;
        end
        tick();
        chk(name, 32'(exp_rsp.size() + exp_req.size()), 0);
    endtask

    initial begin
        #2;
        chk("init_cmd_ready", 32'(cmd_ready), 1);
        chk("init_rsp_valid", 32'(rsp_valid), 0);
        chk("init_req_valid", 32'(read_req.valid), 0);
        chk("init_err", 32'(err), 0);
        tick();
        rst = 1;
        tick();

        // single read
        cmd(8'd3, 4'd0);
        tick();
        tick();
        chk("single_rsp_low", 32'(rsp_valid), 0);
        exp_rsp.push_back('{a: 8'd3, d: mk(8'd3)});
        ret(4'd7, 4'd0, 8'd3, mk(8'd3));
        @(negedge clk);
        chk("single_rsp_next", 32'(rsp_valid), 1);
        tick();
        drain("single_drain");

        // fill, then out-of-order returns
        do_reset();
        rsp_ready = 0;
        for (int i = 0; i < 4; i++) begin
            cmd(addr_t'(i), 4'(i));
        end
        cmd_valid   = 1;
        cmd_address = 8'd4;
        @(negedge clk);
        chk("full_cmd_ready", 32'(cmd_ready), 0);
        tick();
        cmd_valid = 0;
        for (int i = 0; i < 4; i++) begin
            exp_rsp.push_back('{a: addr_t'(i), d: mk(addr_t'(i))});
        end
        ret(4'd7, 4'd2, 8'd2, mk(8'd2));
        @(negedge clk);
        chk("ooo_rsp_low", 32'(rsp_valid), 0);
        tick();
        ret(4'd7, 4'd0, 8'd0, mk(8'd0));
        @(negedge clk);
        chk("ooo_rsp_high", 32'(rsp_valid), 1);
        tick();
        ret(4'd7, 4'd3, 8'd3, mk(8'd3));
        ret(4'd7, 4'd1, 8'd1, mk(8'd1));
        chk("filled_cmd_ready", 32'(cmd_ready), 0);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        @(negedge clk);
        chk("pop_cmd_ready", 32'(cmd_ready), 1);
        tick();
        rsp_ready = 1;
        drain("ooo_drain");

        // foreign id to a pending slot, then bad returns
        do_reset();
        cmd(8'd5, 4'd0);
        ret(4'd9, 4'd0, 8'd5, mk(8'd5));
        @(negedge clk);
        chk("foreign_rsp", 32'(rsp_valid), 0);
        chk("foreign_err", 32'(err), 0);
        tick();
        exp_rsp.push_back('{a: 8'd5, d: mk(8'd5)});
        ret(4'd7, 4'd0, 8'd5, mk(8'd5));
        drain("foreign_drain");
        chk("good_err", 32'(err), 0);
        ret(4'd7, 4'd1, 8'd1, mk(8'd1));
        @(negedge clk);
        chk("free_slot_err", 32'(err), 1);
        tick();
        tick();
        tick();
        chk("err_sticky", 32'(err), 1);
        do_reset();
        ret(4'd7, 4'd5, 8'd0, mk(8'd0));
        @(negedge clk);
        chk("range_err", 32'(err), 1);
        tick();

        // halt blocks commands only
        do_reset();
        cmd(8'd6, 4'd0);
        halt        = 1;
        cmd_valid   = 1;
        cmd_address = 8'd9;
        @(negedge clk);
        chk("halt_cmd_ready", 32'(cmd_ready), 0);
        tick();
        exp_rsp.push_back('{a: 8'd6, d: mk(8'd6)});
        ret(4'd7, 4'd0, 8'd6, mk(8'd6));
        tick();
        chk("halt_req_valid", 32'(read_req.valid), 0);
        drain("halt_drain");
        cmd_valid = 0;
        halt      = 0;

        // reset with two outstanding, then a late return
        do_reset();
        cmd(8'd1, 4'd0);
        cmd(8'd2, 4'd1);
        do_reset();
        ret(4'd7, 4'd0, 8'd1, mk(8'd1));
        @(negedge clk);
        chk("late_err", 32'(err), 1);
        tick();

        // address mismatch on capture
        do_reset();
        cmd(8'd4, 4'd0);
        exp_rsp.push_back('{a: 8'd4, d: mk(8'd4)});
        ret(4'd7, 4'd0, 8'd5, mk(8'd4));
        @(negedge clk);
`ifdef DATA_REQUESTER_ADDR_CHECK_EN
        chk("addr_mismatch_err", 32'(err), 1);
`else
        chk("addr_mismatch_err", 32'(err), 0);
`endif
        tick();
        drain("addr_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_requester.md
DATA_REQUESTER -- requirements
Module: data_requester

Interface
REQ-001 Parameter REQUESTER_ID, default 7, value driven on read_req.request_id; only returns carrying this request_id are accepted.
REQ-002 Parameter DEPTH, default 4, number of outstanding-read slots; power of two, 2..16; slot index is carried in receive_id.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low (asserted when 0).
REQ-005 halt  in  1  stall; while 1 no new command is accepted.
REQ-006 cmd_valid  in  1  consumer read command valid.
REQ-007 cmd_ready  out  1  command accepted on edge where cmd_valid && cmd_ready.
REQ-008 cmd_address  in  read_address width (DataInterface_pkg)  row address to read.
REQ-009 read_req  out  read_request_t  request toward DataInterface read port (valid, request_id, receive_id, read_address).
REQ-010 read_back  in  read_return_t  shared DataInterface return bus.
REQ-011 rsp_valid  out  1  head-slot data available.
REQ-012 rsp_ready  in  1  consumer takes response on edge where rsp_valid && rsp_ready.
REQ-013 rsp_address  out  read_address width  address of delivered row.
REQ-014 rsp_data  out  data_register_union_t  delivered row.
REQ-015 err  out  1  sticky protocol-error flag.

Function
REQ-016 Each slot SHALL hold state FREE, PENDING or FILLED, plus address and data.
REQ-017 Tail pointer (allocation) and head pointer (delivery) SHALL wrap modulo DEPTH.
REQ-018 cmd_ready SHALL equal (slot[tail] == FREE) && !halt, combinational from registered state.
REQ-019 On command accept at edge N: slot[tail] -> PENDING, address stored, tail+1; read_req.valid=1 with request_id=REQUESTER_ID, receive_id=old tail, read_address=cmd_address during cycle N+1 only (registered, one-cycle pulse).
REQ-020 read_req.valid SHALL be 0 in any cycle not following an accept; back-to-back accepts SHALL produce back-to-back pulses.
REQ-021 read_back.valid is a one-cycle pulse per return; on an edge with read_back.valid && request_id==REQUESTER_ID && slot[receive_id]==PENDING, slot -> FILLED and read_back.data captured.
REQ-022 Returns with another request_id SHALL be ignored without side effect.
REQ-023 Returns with matching request_id to a FREE or FILLED slot, or receive_id >= DEPTH, SHALL be discarded and set err.
REQ-024 Returns MAY arrive out of issue order; responses SHALL be delivered strictly in issue order.
REQ-025 rsp_valid SHALL equal (slot[head] == FILLED); rsp_address/rsp_data from slot[head]; earliest rsp_valid is the cycle after capture.
REQ-026 On response handshake: slot[head] -> FREE, head+1; slot reusable by a command on the following edge, not the same one.
REQ-027 Command accept, return capture and response handshake on the same edge SHALL all take effect independently.
REQ-028 halt SHALL not block return capture or response delivery.
REQ-029 Full (all slots non-FREE): cmd_ready=0. Empty (all FREE): rsp_valid=0.

Reset
REQ-030 rst=0 SHALL immediately clear: all slots FREE, head=tail=0, read_req=0, err=0; rsp_valid and cmd_ready follow as 0 and !halt.
REQ-031 Reset mid-operation discards outstanding reads; their later returns hit FREE slots and set err per REQ-023.

Configuration
REQ-032 Macro DATA_REQUESTER_ADDR_CHECK_EN defined: on capture, read_back.read_address != stored slot address SHALL set err (data still captured). Undefined: no address comparison, err only per REQ-023.

Verification
REQ-033 Single read: cmd addr 3, return id 7/rcv 0 addr 3 data u32[3]=3 three cycles later -> read_req pulse one cycle after accept, rsp_valid next cycle after return, rsp_address=3, rsp_data.u32[3]=3.
REQ-034 Fill: 4 commands addr 0..3, no returns -> 4 pulses rcv 0..3, cmd_ready=0 after 4th; one response consumed -> cmd_ready=1.
REQ-035 Out-of-order: returns rcv 2,0,3,1 -> responses delivered addr 0,1,2,3 in order; rsp_valid low until rcv 0 returns.
REQ-036 Foreign/bad returns: request_id 9 -> ignored, err=0; request_id 7 to FREE slot 1 -> err=1 and stays 1.
REQ-037 halt=1 with cmd_valid=1 -> cmd_ready=0, no read_req; a PENDING return still captured and delivered.
REQ-038 Reset with 2 PENDING -> all outputs cleared asynchronously; late return rcv 0 -> err=1; with DATA_REQUESTER_ADDR_CHECK_EN, mismatched return address -> err=1.
